fill_1x2: RTL and testbench



---
 rtl/fill_1x2.sv | 177 +++++++++++++++++
 tb/tb_fill_1x2.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/fill_1x2.sv
// Horizontal 1:2 pixel restorer: turns alternate-slot de_i into a contiguous de_o run.
// Optional macro FILL_AVG_EN: interpolate the second slot (latency 4 instead of 2).
module fill_1x2 #(
  parameter int DW = 8
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          vs_i,
  input  logic          hs_i,
  input  logic          de_i,
  input  logic [DW-1:0] rgb_r_i,
  input  logic [DW-1:0] rgb_g_i,
  input  logic [DW-1:0] rgb_b_i,
  input  logic [7:0]    image_mode_i,
  output logic          vs_o,
  output logic          hs_o,
  output logic          de_o,
  output logic [DW-1:0] rgb_r_o,
  output logic [DW-1:0] rgb_g_o,
  output logic [DW-1:0] rgb_b_o,
  output logic          fill_err_o
);

  localparam int PW = 3 * DW;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    DUP  = 1'b1
  } state_t;

  logic          vs0_q, hs0_q, de0_q, mode_q;
  logic [PW-1:0] pix0_q;
  logic          vs_f_s, hs_f_s, de_f_s, mode_f_s;
  logic [PW-1:0] pix_f_s, second_s;
  state_t        state_q, state_d;
  logic [PW-1:0] hold_q, hold_d;
  logic          vs_out_q, hs_out_q, de_out_q, de_out_d, err_q, err_d;
  logic [PW-1:0] pix_out_q, pix_out_d;
  logic          mode_unused_s;

  assign mode_unused_s = ^image_mode_i[7:1];

  // Input stage and per-frame mode latch on the vs_i rising edge
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      vs0_q  <= 1'b0;
      hs0_q  <= 1'b0;
      de0_q  <= 1'b0;
      pix0_q <= {PW{1'b0}};
      mode_q <= 1'b0;
    end else begin
      vs0_q  <= vs_i;
      hs0_q  <= hs_i;
      de0_q  <= de_i;
      pix0_q <= {rgb_r_i, rgb_g_i, rgb_b_i};
      if (vs_i && !vs0_q) begin
        mode_q <= image_mode_i[0];
      end else begin
        mode_q <= mode_q;
      end
    end
  end

`ifdef FILL_AVG_EN
  logic          vs1_q, hs1_q, de1_q, mode1_q;
  logic          vs2_q, hs2_q, de2_q, mode2_q;
  logic [PW-1:0] pix1_q, pix2_q;

  function automatic logic [PW-1:0] avg_pix(input logic [PW-1:0] a, input logic [PW-1:0] b);
    logic [PW-1:0] res;
    logic [DW:0]   sum;
    res = {PW{1'b0}};
    for (int c = 0; c < 3; c++) begin
      sum = {1'b0, a[c*DW +: DW]} + {1'b0, b[c*DW +: DW]} + {{DW{1'b0}}, 1'b1};
      res[c*DW +: DW] = sum[DW:1];
    end
    return res;
  endfunction

  // Two extra stages; stage 1 serves as one-slot look-ahead for the fill stage
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      {vs1_q, hs1_q, de1_q, mode1_q} <= 4'b0000;
      {vs2_q, hs2_q, de2_q, mode2_q} <= 4'b0000;
      pix1_q <= {PW{1'b0}};
      pix2_q <= {PW{1'b0}};
    end else begin
      {vs1_q, hs1_q, de1_q, mode1_q} <= {vs0_q, hs0_q, de0_q, mode_q};
      {vs2_q, hs2_q, de2_q, mode2_q} <= {vs1_q, hs1_q, de1_q, mode1_q};
      pix1_q <= pix0_q;
      pix2_q <= pix1_q;
    end
  end

  assign {vs_f_s, hs_f_s, de_f_s, mode_f_s} = {vs2_q, hs2_q, de2_q, mode2_q};
  assign pix_f_s  = pix2_q;
  assign second_s = de1_q ? avg_pix(hold_q, pix1_q) : hold_q;
`else
  assign {vs_f_s, hs_f_s, de_f_s, mode_f_s} = {vs0_q, hs0_q, de0_q, mode_q};
  assign pix_f_s  = pix0_q;
  assign second_s = hold_q;
`endif

  // Fill FSM next state and output-stage data
  always_comb begin
    state_d   = state_q;
    hold_d    = hold_q;
    de_out_d  = 1'b0;
    pix_out_d = pix_out_q;
    err_d     = 1'b0;
    if (!mode_f_s) begin
      state_d   = IDLE;
      de_out_d  = de_f_s;
      pix_out_d = pix_f_s;
    end else begin
      case (state_q)
        IDLE: begin
          if (de_f_s) begin
            de_out_d  = 1'b1;
            pix_out_d = pix_f_s;
            hold_d    = pix_f_s;
            state_d   = DUP;
          end else begin
            de_out_d  = 1'b0;
          end
        end
        DUP: begin
          if (de_f_s) begin
            // back-to-back kept pixels: newest wins, flag the malformed line
            de_out_d  = 1'b1;
            pix_out_d = pix_f_s;
            hold_d    = pix_f_s;
            err_d     = 1'b1;
            state_d   = DUP;
          end else begin
            de_out_d  = 1'b1;
            pix_out_d = second_s;
            state_d   = IDLE;
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // FSM, hold and registered output stage
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      hold_q    <= {PW{1'b0}};
      vs_out_q  <= 1'b0;
      hs_out_q  <= 1'b0;
      de_out_q  <= 1'b0;
      err_q     <= 1'b0;
      pix_out_q <= {PW{1'b0}};
    end else begin
      state_q   <= state_d;
      hold_q    <= hold_d;
      vs_out_q  <= vs_f_s;
      hs_out_q  <= hs_f_s;
      de_out_q  <= de_out_d;
      err_q     <= err_d;
      pix_out_q <= pix_out_d;
    end
  end

  assign vs_o       = vs_out_q;
  assign hs_o       = hs_out_q;
  assign de_o       = de_out_q;
  assign fill_err_o = err_q;
  assign rgb_r_o    = pix_out_q[3*DW-1:2*DW];
  assign rgb_g_o    = pix_out_q[2*DW-1:DW];
  assign rgb_b_o    = pix_out_q[DW-1:0];

endmodule

// File: tb/tb_fill_1x2.sv
// Randomized self-checking bench for fill_1x2 against a slot-based reference model.
module tb_fill_1x2;

`ifdef FILL_AVG_EN
  localparam int LAT = 4;
  localparam bit AVG = 1'b1;
`else
  localparam int LAT = 2;
  localparam bit AVG = 1'b0;
`endif
  localparam int N = 8192;

  logic       clock, reset_n;
  logic       vs_i, hs_i, de_i;
  logic [7:0] rgb_r_i, rgb_g_i, rgb_b_i, image_mode_i;
  logic       vs_o, hs_o, de_o, fill_err_o;
  logic [7:0] rgb_r_o, rgb_g_o, rgb_b_o;

  fill_1x2 #(.DW(8)) dut (
    .clock(clock), .reset_n(reset_n),
    .vs_i(vs_i), .hs_i(hs_i), .de_i(de_i),
    .rgb_r_i(rgb_r_i), .rgb_g_i(rgb_g_i), .rgb_b_i(rgb_b_i),
    .image_mode_i(image_mode_i),
    .vs_o(vs_o), .hs_o(hs_o), .de_o(de_o),
    .rgb_r_o(rgb_r_o), .rgb_g_o(rgb_g_o), .rgb_b_o(rgb_b_o),
    .fill_err_o(fill_err_o)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // recorded input history, one entry per input slot
  bit        s_vs[N], s_hs[N], s_de[N], s_mode[N];
  bit [23:0] s_pix[N];
  int        cur, base, n_cmp, n_bad;
  bit        prev_vs, cur_mode;
  bit [23:0] last_rgb;
  bit [7:0]  im_drv;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%07h exp=%07h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit [7:0] avg8(input bit [7:0] a, input bit [7:0] b);
    int s;
    s = (int'(a) + int'(b) + 1) / 2;
    return s[7:0];
  endfunction

  // expected {vs,hs,de,err,r,g,b} for output slot k
  task automatic model(input int k, output logic [31:0] exp);
    bit        prev_kept, de_x, err_x;
    bit [23:0] rgb_x, p, q;
    if (k < base) begin
      exp = 32'h0;
    end else begin
      prev_kept = (k - 1 >= base) && s_mode[k-1] && s_de[k-1];
      de_x = 1'b0; err_x = 1'b0; rgb_x = last_rgb;
      if (!s_mode[k]) begin
        de_x = s_de[k]; rgb_x = s_pix[k];
      end else if (s_de[k]) begin
        de_x = 1'b1; rgb_x = s_pix[k]; err_x = prev_kept;
      end else if (prev_kept) begin
        de_x = 1'b1; rgb_x = s_pix[k-1];
        if (AVG && s_de[k+1]) begin
          p = s_pix[k-1]; q = s_pix[k+1];
          rgb_x = {avg8(p[23:16], q[23:16]), avg8(p[15:8], q[15:8]), avg8(p[7:0], q[7:0])};
        end
      end
      last_rgb = rgb_x;
      exp = {4'h0, s_vs[k], s_hs[k], de_x, err_x, rgb_x};
    end
  endtask

  // drive one slot (called just after a falling edge), then check the output slot now visible
  task automatic drive(input bit vs, input bit hs, input bit de, input bit [23:0] pix);
    logic [31:0] exp;
    vs_i = vs; hs_i = hs; de_i = de;
    {rgb_r_i, rgb_g_i, rgb_b_i} = pix;
    image_mode_i = im_drv;
    if (vs && !prev_vs) cur_mode = im_drv[0];
    prev_vs = vs;
    s_vs[cur] = vs; s_hs[cur] = hs; s_de[cur] = de; s_pix[cur] = pix; s_mode[cur] = cur_mode;
    s_de[cur+1] = 1'b0;
    cur++;
    @(posedge clock);
    @(negedge clock);
    model(cur - LAT, exp);
    check_eq("out", {4'h0, vs_o, hs_o, de_o, fill_err_o, rgb_r_o, rgb_g_o, rgb_b_o}, exp);
  endtask

  task automatic blank(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0, 24'($urandom));
  endtask

  task automatic vsync(input bit [7:0] im);
    im_drv = im;
    for (int i = 0; i < 3; i++) drive(1'b1, 1'b0, 1'b0, 24'($urandom));
    blank(4);
  endtask

  task automatic hsync();
    for (int i = 0; i < 2; i++) drive(1'b0, 1'b1, 1'b0, 24'($urandom));
    blank(3);
  endtask

  task automatic px(input bit [7:0] r);
    drive(1'b0, 1'b0, 1'b1, {r, 16'($urandom)});
  endtask

  task automatic rand_line(input int pat);
    int len;
    bit de;
    hsync();
    len = $urandom_range(20, 40);
    for (int i = 0; i < len; i++) begin
      case (pat)
        0:       de = (i % 2 == 0);
        1:       de = ($urandom_range(0, 9) < 4);
        default: de = (i % 2 == 0) ^ ($urandom_range(0, 7) == 0);
      endcase
      drive(1'b0, 1'b0, de, 24'($urandom));
    end
    blank(6);
  endtask

  task automatic do_reset();
    #2 reset_n = 1'b0;
    #1 check_eq("rst_async", {4'h0, vs_o, hs_o, de_o, fill_err_o, rgb_r_o, rgb_g_o, rgb_b_o}, 32'h0);
    @(posedge clock);
    @(negedge clock);
    #2 reset_n = 1'b1;
    prev_vs = 1'b0; cur_mode = 1'b0; last_rgb = 24'h0; base = cur;
  endtask

  initial begin
    n_cmp = 0; n_bad = 0; cur = 0; base = 0;
    prev_vs = 1'b0; cur_mode = 1'b0; last_rgb = 24'h0; im_drv = 8'h00;
    reset_n = 1'b0;
    {vs_i, hs_i, de_i} = 3'b000;
    {rgb_r_i, rgb_g_i, rgb_b_i} = 24'h0;
    image_mode_i = 8'h00;
    @(negedge clock);
    #1 check_eq("rst_state", {4'h0, vs_o, hs_o, de_o, fill_err_o, rgb_r_o, rgb_g_o, rgb_b_o}, 32'h0);
    @(negedge clock);
    #2 reset_n = 1'b1;

    // bypass, contiguous de with rgb_r = 0..7
    vsync(8'hfe);
    hsync();
    for (int i = 0; i < 8; i++) px(8'(i));
    blank(6);

    // mode word changes mid-frame: stays bypass until next vs rise
    im_drv = 8'h01;
    rand_line(0);
    vsync(8'h01);

    // fill basic, 10/20/30/40 on alternate slots
    hsync();
    for (int i = 1; i <= 4; i++) begin
      px(8'(10 * i));
      blank(1);
    end
    blank(6);

    // malformed: two consecutive kept pixels then a gap
    hsync();
    px(8'd5);
    px(8'd6);
    blank(6);

`ifdef FILL_AVG_EN
    hsync();
    px(8'd10); blank(1); px(8'd21); blank(1); px(8'd255);
    blank(8);
`endif

    // asynchronous reset while a duplicate is pending
    hsync();
    px(8'd77);
    do_reset();
    rand_line(0);
    rand_line(1);

    for (int f = 0; f < 10; f++) begin
      vsync(8'($urandom));
      for (int l = 0; l < 4; l++) rand_line(int'($urandom_range(0, 2)));
      if (f == 5) begin
        hsync();
        px(8'($urandom));
        do_reset();
      end
    end
    blank(LAT + 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
